mtr_drv_nch: RTL and testbench

Parametrised N-channel H-bridge motor driver, the next-generation motor output stage of the segway controller. One shared free-running PWM period counter feeds NCH per-channel generators. Each channel converts a magnitude/direction command into forward/reverse PWM pins. Over the fixed two-motor driver it adds:
- duty and direction updates synchronised to the PWM period boundary
- dead-time insertion on direction reversal
- a global synchronous enable
- a period-start strobe for the control loop

---
 rtl/mtr_drv_pkg.sv | 26 ++
 rtl/mtr_chan.sv | 100 ++++++++++
 rtl/mtr_drv_nch.sv | 80 ++++++++
 tb/tb_mtr_drv_nch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mtr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_pkg
// Brief    : Shared types, default constants and bus helpers for mtr_drv_nch.
// Revision : 1.0 - initial release
// ============================================================================
package mtr_drv_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chan_state_t;

    localparam int c_pwm_w_dflt    = 11;
    localparam int c_dead_cyc_dflt = 64;
    localparam int c_bus_max_w     = 1024;

    // Caller zero-extends the packed spd bus to c_bus_max_w and truncates the result to PWM_W.
    function automatic logic [31:0] chan_spd(input logic [c_bus_max_w-1:0] bus,
                                             input int ch,
                                             input int w);
        return 32'(bus >> (ch * w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_chan.sv
`default_nettype none
// ============================================================================
// Module   : mtr_chan
// Brief    : One H-bridge channel: boundary-latched duty/direction, dead-time
//            FSM and registered forward/reverse PWM pins.
//            Optional short brake under MTR_DRV_BRAKE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mtr_chan
    import mtr_drv_pkg::*;
#(
    parameter int PWM_W    = c_pwm_w_dflt,
    parameter int DEAD_CYC = c_dead_cyc_dflt
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bnd,
    input  logic [PWM_W-1:0] cnt_nxt,
    input  logic [PWM_W-1:0] spd,
    input  logic             rev,
`ifdef MTR_DRV_BRAKE_EN
    input  logic             brk,
`endif
    output logic             pwm_frwrd,
    output logic             pwm_rev
);

    localparam bit               c_dead_en = (DEAD_CYC > 0);
    localparam logic [PWM_W-1:0] c_dead_ld = c_dead_en ? PWM_W'(DEAD_CYC - 1) : '0;
    localparam logic [PWM_W-1:0] c_one     = PWM_W'(1);

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] w_duty_nxt;
    logic [PWM_W-1:0] r_dead_cnt;
    logic [PWM_W-1:0] w_dead_nxt;
    logic             r_rev;
    logic             w_rev_nxt;
    logic             w_rev_chg;
    logic             w_sig;
    logic             w_frwrd_d;
    logic             w_rev_d;
    logic             r_frwrd;
    logic             r_rev_pin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_duty     <= '0;
            r_dead_cnt <= '0;
            r_rev      <= 1'b0;
            r_frwrd    <= 1'b0;
            r_rev_pin  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_rev      <= w_rev_nxt;
            r_frwrd    <= w_frwrd_d;
            r_rev_pin  <= w_rev_d;
        end
    end

    // Pins are registered from next-cycle values so each pin lines up with the counter value it compares.
    always_comb begin
        w_duty_nxt  = bnd ? spd : r_duty;
        w_rev_chg   = bnd && (rev != r_rev);
        w_rev_nxt   = w_rev_chg ? rev : r_rev;
        w_state_nxt = r_state;
        w_dead_nxt  = r_dead_cnt;

        if (w_rev_chg && c_dead_en) begin
            w_state_nxt = DEAD;
            w_dead_nxt  = c_dead_ld;
        end else if (r_state == DEAD) begin
            if (r_dead_cnt == '0) begin
                w_state_nxt = RUN;
            end else begin
                w_dead_nxt = r_dead_cnt - c_one;
            end
        end

        w_sig     = (w_state_nxt == RUN) && (cnt_nxt < w_duty_nxt);
        w_frwrd_d = en && w_sig && !w_rev_nxt;
        w_rev_d   = en && w_sig && w_rev_nxt;
`ifdef MTR_DRV_BRAKE_EN
        if (en && brk) begin
            w_frwrd_d = 1'b1;
            w_rev_d   = 1'b1;
        end
`endif
    end

    assign pwm_frwrd = r_frwrd;
    assign pwm_rev   = r_rev_pin;

endmodule
`default_nettype wire

// File: rtl/mtr_drv_nch.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_nch
// Brief    : N-channel H-bridge PWM driver: shared period counter, boundary
//            decode, period-start strobe and NCH channel generators.
//            Define MTR_DRV_BRAKE_EN to add the per-channel brk input.
// Revision : 1.0 - initial release
// ============================================================================
module mtr_drv_nch
    import mtr_drv_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int PWM_W    = c_pwm_w_dflt,
    parameter int DEAD_CYC = c_dead_cyc_dflt
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH*PWM_W-1:0] spd,
    input  logic [NCH-1:0]       rev,
`ifdef MTR_DRV_BRAKE_EN
    input  logic [NCH-1:0]       brk,
`endif
    output logic [NCH-1:0]       pwm_frwrd,
    output logic [NCH-1:0]       pwm_rev,
    output logic                 prd_strt
);

    localparam logic [PWM_W-1:0] c_cnt_max = '1;
    localparam logic [PWM_W-1:0] c_one     = PWM_W'(1);

    logic [PWM_W-1:0]       r_cnt;
    logic [PWM_W-1:0]       w_cnt_nxt;
    logic                   w_bnd;
    logic                   r_prd_strt;
    logic [c_bus_max_w-1:0] w_spd_ext;

    assign w_cnt_nxt = r_cnt + c_one;
    assign w_bnd     = (r_cnt == c_cnt_max);
    assign w_spd_ext = c_bus_max_w'(spd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_prd_strt <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_prd_strt <= w_bnd;
        end
    end

    assign prd_strt = r_prd_strt;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            logic [PWM_W-1:0] w_spd_ch;
            assign w_spd_ch = PWM_W'(chan_spd(w_spd_ext, i, PWM_W));

            mtr_chan #(
                .PWM_W    (PWM_W),
                .DEAD_CYC (DEAD_CYC)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (en),
                .bnd       (w_bnd),
                .cnt_nxt   (w_cnt_nxt),
                .spd       (w_spd_ch),
                .rev       (rev[i]),
`ifdef MTR_DRV_BRAKE_EN
                .brk       (brk[i]),
`endif
                .pwm_frwrd (pwm_frwrd[i]),
                .pwm_rev   (pwm_rev[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtr_drv_nch
// Brief    : Directed self-checking bench for mtr_drv_nch (NCH=2, PWM_W=11,
//            DEAD_CYC=64); brake scenario only when MTR_DRV_BRAKE_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtr_drv_nch;

    localparam int NCH   = 2;
    localparam int PWM_W = 11;
    localparam int PER   = 2048;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [NCH*PWM_W-1:0] spd;
    logic [NCH-1:0]       rev;
`ifdef MTR_DRV_BRAKE_EN
    logic [NCH-1:0]       brk;
`endif
    logic [NCH-1:0]       pwm_frwrd;
    logic [NCH-1:0]       pwm_rev;
    logic                 prd_strt;

    int n_tot = 0;
    int n_bad = 0;
    int hf0, hr0, hf1, hr1, both, strt, first_on0, low1_idx;
    int ev_spd_at, ev_rev_at, ev_en_off, ev_en_on;
    logic [NCH*PWM_W-1:0] ev_spd_bus;
    logic [NCH-1:0]       ev_rev_val;

    mtr_drv_nch #(
        .NCH      (NCH),
        .PWM_W    (PWM_W),
        .DEAD_CYC (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .spd       (spd),
        .rev       (rev),
`ifdef MTR_DRV_BRAKE_EN
        .brk       (brk),
`endif
        .pwm_frwrd (pwm_frwrd),
        .pwm_rev   (pwm_rev),
        .prd_strt  (prd_strt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic clear_ev();
        ev_spd_at = -1; ev_rev_at = -1; ev_en_off = -1; ev_en_on = -1;
    endtask

    // Samples one full period starting at a prd_strt negedge, applying any scheduled input events.
    task automatic measure();
        hf0 = 0; hr0 = 0; hf1 = 0; hr1 = 0; both = 0; strt = 0; first_on0 = -1; low1_idx = -1;
        for (int i = 0; i < PER; i++) begin
            if (pwm_frwrd[0]) hf0++;
            if (pwm_rev[0])   hr0++;
            if (pwm_frwrd[1]) hf1++;
            if (pwm_rev[1])   hr1++;
            if (|(pwm_frwrd & pwm_rev)) both++;
            if (prd_strt) strt++;
            if (first_on0 < 0 && (pwm_frwrd[0] || pwm_rev[0])) first_on0 = i;
            if (!pwm_frwrd[1]) low1_idx = i;
            if (i == ev_spd_at) spd = ev_spd_bus;
            if (i == ev_rev_at) rev = ev_rev_val;
            if (i == ev_en_off) en = 1'b0;
            if (i == ev_en_on)  en = 1'b1;
            @(negedge clk);
        end
        clear_ev();
    endtask

    task automatic test_reset();
        int n, hi;
        rst_n = 1'b0; en = 1'b1; rev = '0;
        spd = {11'd300, 11'd512};
`ifdef MTR_DRV_BRAKE_EN
        brk = '0;
`endif
        clear_ev();
        repeat (3) @(negedge clk);
        n_tot++; if (pwm_frwrd !== 2'b00) begin n_bad++; $display("FAIL rst_frwrd: got %b want 00", pwm_frwrd); end
        n_tot++; if (pwm_rev !== 2'b00) begin n_bad++; $display("FAIL rst_rev: got %b want 00", pwm_rev); end
        n_tot++; if (prd_strt !== 1'b0) begin n_bad++; $display("FAIL rst_strt: got %b want 0", prd_strt); end
        rst_n = 1'b1;
        n = 0; hi = 0;
        while (prd_strt !== 1'b1 && n < 4200) begin
            if (|pwm_frwrd || |pwm_rev) hi++;
            @(negedge clk);
            n++;
        end
        n_tot++; if (n != 2048) begin n_bad++; $display("FAIL rst_first_strt: got %0d clocks want 2048", n); end
        n_tot++; if (hi != 0) begin n_bad++; $display("FAIL rst_first_period_pins: got %0d high clocks want 0", hi); end
    endtask

    task automatic test_duty();
        measure();
        n_tot++; if (hf0 != 512) begin n_bad++; $display("FAIL duty_frwrd0: got %0d want 512", hf0); end
        n_tot++; if (hr0 != 0) begin n_bad++; $display("FAIL duty_rev0: got %0d want 0", hr0); end
        n_tot++; if (hf1 != 300 || hr1 != 0) begin n_bad++; $display("FAIL duty_ch1: got f=%0d r=%0d want 300/0", hf1, hr1); end
        n_tot++; if (strt != 1) begin n_bad++; $display("FAIL duty_strt_count: got %0d want 1", strt); end
        n_tot++; if (prd_strt !== 1'b1) begin n_bad++; $display("FAIL duty_strt_period: got %b want 1 after 2048 clocks", prd_strt); end
        n_tot++; if (both != 0) begin n_bad++; $display("FAIL duty_overlap: got %0d want 0", both); end
    endtask

    task automatic test_spd_change();
        ev_spd_at = 100; ev_spd_bus = {11'd300, 11'd1024};
        measure();
        n_tot++; if (hf0 != 512) begin n_bad++; $display("FAIL chg_old_period: got %0d want 512", hf0); end
        measure();
        n_tot++; if (hf0 != 1024) begin n_bad++; $display("FAIL chg_new_period: got %0d want 1024", hf0); end
    endtask

    task automatic test_reverse();
        ev_spd_at = 10; ev_spd_bus = {11'd300, 11'd1000};
        ev_rev_at = 10; ev_rev_val = 2'b01;
        measure();
        n_tot++; if (hf0 != 1024 || hr0 != 0) begin n_bad++; $display("FAIL rev_midperiod: got f=%0d r=%0d want 1024/0", hf0, hr0); end
        measure();
        n_tot++; if (hr0 != 936) begin n_bad++; $display("FAIL rev_high: got %0d want 936", hr0); end
        n_tot++; if (hf0 != 0) begin n_bad++; $display("FAIL rev_frwrd: got %0d want 0", hf0); end
        n_tot++; if (first_on0 != 64) begin n_bad++; $display("FAIL rev_dead_len: got %0d want 64", first_on0); end
        n_tot++; if (both != 0) begin n_bad++; $display("FAIL rev_overlap: got %0d want 0", both); end
    endtask

    task automatic test_corner();
        ev_spd_at = 10; ev_spd_bus = {11'd2047, 11'd0};
        measure();
        n_tot++; if (hr0 != 1000 || hf0 != 0) begin n_bad++; $display("FAIL corner_steady_rev: got f=%0d r=%0d want 0/1000", hf0, hr0); end
        measure();
        n_tot++; if (hf0 != 0 || hr0 != 0) begin n_bad++; $display("FAIL corner_zero: got f=%0d r=%0d want 0/0", hf0, hr0); end
        n_tot++; if (hf1 != 2047) begin n_bad++; $display("FAIL corner_max: got %0d want 2047", hf1); end
        n_tot++; if (low1_idx != 2047) begin n_bad++; $display("FAIL corner_max_low_pos: got %0d want 2047", low1_idx); end
    endtask

    task automatic test_en();
        ev_en_off = 1500; ev_spd_at = 1800; ev_spd_bus = {11'd100, 11'd0};
        measure();
        n_tot++; if (hf1 != 1501) begin n_bad++; $display("FAIL en_off: got %0d want 1501", hf1); end
        ev_en_on = 50;
        measure();
        n_tot++; if (hf1 != 49) begin n_bad++; $display("FAIL en_on_latched: got %0d want 49", hf1); end
        n_tot++; if (strt != 1) begin n_bad++; $display("FAIL en_strt: got %0d want 1", strt); end
    endtask

`ifdef MTR_DRV_BRAKE_EN
    task automatic test_brake();
        int n;
        brk = 2'b10;
        @(negedge clk);
        n_tot++; if (pwm_frwrd[1] !== 1'b1 || pwm_rev[1] !== 1'b1) begin n_bad++; $display("FAIL brk_on: got f=%b r=%b want 1/1", pwm_frwrd[1], pwm_rev[1]); end
        en = 1'b0;
        @(negedge clk);
        n_tot++; if (pwm_frwrd[1] !== 1'b0 || pwm_rev[1] !== 1'b0) begin n_bad++; $display("FAIL brk_en_off: got f=%b r=%b want 0/0", pwm_frwrd[1], pwm_rev[1]); end
        en = 1'b1; brk = '0;
        n = 0;
        while (prd_strt !== 1'b1 && n < 4200) begin @(negedge clk); n++; end
        n_tot++; if (prd_strt !== 1'b1) begin n_bad++; $display("FAIL brk_resync: got %b want 1", prd_strt); end
    endtask
`endif

    task automatic test_reset_mid();
        int n, hi;
        ev_spd_at = 10; ev_spd_bus = {11'd100, 11'd1500};
        ev_rev_at = 10; ev_rev_val = 2'b00;
        measure();
        n_tot++; if (hf1 != 100) begin n_bad++; $display("FAIL rmid_ch1: got %0d want 100", hf1); end
        repeat (20) @(negedge clk);
        n_tot++; if (pwm_frwrd[0] !== 1'b0 || pwm_rev[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_dead: got f=%b r=%b want 0/0", pwm_frwrd[0], pwm_rev[0]); end
        n_tot++; if (pwm_frwrd[1] !== 1'b1) begin n_bad++; $display("FAIL rmid_ch1_pre: got %b want 1", pwm_frwrd[1]); end
        rst_n = 1'b0;
        #1;
        n_tot++; if (pwm_frwrd !== 2'b00 || pwm_rev !== 2'b00) begin n_bad++; $display("FAIL rmid_async: got f=%b r=%b want 00/00", pwm_frwrd, pwm_rev); end
        n_tot++; if (prd_strt !== 1'b0) begin n_bad++; $display("FAIL rmid_strt: got %b want 0", prd_strt); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; hi = 0;
        while (prd_strt !== 1'b1 && n < 4200) begin
            if (|pwm_frwrd || |pwm_rev) hi++;
            @(negedge clk);
            n++;
        end
        n_tot++; if (n != 2048) begin n_bad++; $display("FAIL rmid_first_strt: got %0d clocks want 2048", n); end
        n_tot++; if (hi != 0) begin n_bad++; $display("FAIL rmid_first_period_pins: got %0d high clocks want 0", hi); end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_spd_change();
        test_reverse();
        test_corner();
        test_en();
`ifdef MTR_DRV_BRAKE_EN
        test_brake();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
